spi_master: RTL and testbench

- SPI controller (mode 0, MSB first) that drives sclk/ce0/mosi and samples miso.
- It is the initiator end of the link, used to exercise or talk to the existing SPI peripheral block from another iCE40 design or a bench.
- A local start/busy/done handshake launches one word per request and returns the received word.
- All timing derives from the single system clock; sclk is a divided, registered output.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_tick.sv | 35 +++
 rtl/spi_master.sv | 149 ++++++++++++++
 tb/tb_spi_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: FSM state encoding, mode constants, default word width
package spi_pkg;

  // SPI mode 0: sclk idles low, data sampled on the rising edge
  localparam int SPI_CPOL = 0;
  localparam int SPI_CPHA = 0;

  localparam int SPI_DEF_WIDTH = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

endpackage

// File: rtl/spi_clk_tick.sv
// rtl/spi_clk_tick.sv - half-period tick generator, counter modulo CLK_DIV
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : count while high; counter held at zero while low
//   clr        : restart the half-period from zero on the next edge
//   tick       : one-cycle pulse on the last cycle of each half-period
module spi_clk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode 0 master, MSB first, one word per start request
//
// Optional burst mode: SPI_MASTER_BURST_EN (adds the cont input and PAUSE state).
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : transfer request, sampled only when idle (or paused)
//   cont       : (burst build) keep ce0 low after this word
//   tx_data    : word to send, captured on the accept edge
//   busy       : high from accept until done
//   done       : one-cycle pulse, rx_data valid from this cycle
//   rx_data    : last received word, updated only at done
//   sclk, mosi, ce0 : SPI outputs (sclk idles low, ce0 active low)
//   miso       : SPI input, sampled on the edge that raises sclk
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_DEF_WIDTH,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SPI_MASTER_BURST_EN
  input  logic             cont,
`endif
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  output logic             ce0,
  input  logic             miso
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [BW-1:0]    bit_cnt;
  logic             trail_end;
  logic             tick;
  logic             tick_en;
  logic             accept;
`ifdef SPI_MASTER_BURST_EN
  logic             cont_q;
`endif

  assign accept  = start && ((state == ST_IDLE) || (state == ST_PAUSE));
  assign tick_en = (state != ST_IDLE) && (state != ST_PAUSE);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      trail_end <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ce0       <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
      cont_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_sr   <= tx_data;
        mosi    <= tx_data[WIDTH-1];
        ce0     <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= '0;
        // A paused burst already satisfied the select lead time
        state   <= (state == ST_PAUSE) ? ST_XFER : ST_LEAD;
`ifdef SPI_MASTER_BURST_EN
        cont_q  <= cont;
`endif
      end else begin
        case (state)
          ST_IDLE: ;
          ST_LEAD: begin
            if (tick) state <= ST_XFER;
          end
          ST_XFER: begin
            if (tick) begin
              if (!sclk) begin
                sclk  <= 1'b1;
                rx_sr <= {rx_sr[WIDTH-2:0], miso};
              end else begin
                sclk <= 1'b0;
                if (bit_cnt == LAST_BIT) begin
                  // mosi keeps the last bit after the word
`ifdef SPI_MASTER_BURST_EN
                  if (cont_q) begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    rx_data <= rx_sr;
                    state   <= ST_PAUSE;
                  end else begin
                    state <= ST_TRAIL;
                  end
`else
                  state <= ST_TRAIL;
`endif
                end else begin
                  bit_cnt <= bit_cnt + BW'(1);
                  tx_sr   <= tx_sr << 1;
                  mosi    <= tx_sr[WIDTH-2];
                end
              end
            end
          end
          ST_TRAIL: begin
            // Hold CLK_DIV cycles, then release ce0 and report on the following edge
            if (trail_end) begin
              trail_end <= 1'b0;
              ce0       <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              rx_data   <= rx_sr;
              state     <= ST_IDLE;
            end else if (tick) begin
              trail_end <= 1'b1;
            end
          end
`ifdef SPI_MASTER_BURST_EN
          ST_PAUSE: ;
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a behavioural timing model
module tb_spi_master;

  localparam int W8  = 8;
  localparam int D8  = 2;
  localparam int W16 = 16;
  localparam int D16 = 1;
  localparam int L8  = 1 + D8 * (2 * W8 + 2);
  localparam int L16 = 1 + D16 * (2 * W16 + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, busy8, done8, sclk8, mosi8, ce08, miso8;
  logic [7:0]  tx8, rx8;
  logic        start16, busy16, done16, sclk16, mosi16, ce016, miso16;
  logic [15:0] tx16, rx16;
`ifdef SPI_MASTER_BURST_EN
  logic        cont8, cont16;
`endif

  int checks = 0;
  int errors = 0;

  logic       loop8;
  logic [7:0] reply;
  logic [7:0] slave_rx;
  logic       slave_bit;
  int         sbit;
  int         rise_cnt;

  assign miso8  = loop8 ? mosi8 : slave_bit;
  assign miso16 = mosi16;

  spi_master #(.WIDTH(W8), .CLK_DIV(D8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
`ifdef SPI_MASTER_BURST_EN
    .cont(cont8),
`endif
    .tx_data(tx8), .busy(busy8), .done(done8), .rx_data(rx8),
    .sclk(sclk8), .mosi(mosi8), .ce0(ce08), .miso(miso8)
  );

  spi_master #(.WIDTH(W16), .CLK_DIV(D16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
`ifdef SPI_MASTER_BURST_EN
    .cont(cont16),
`endif
    .tx_data(tx16), .busy(busy16), .done(done16), .rx_data(rx16),
    .sclk(sclk16), .mosi(mosi16), .ce0(ce016), .miso(miso16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mode-0 slave: presents its reply MSB when selected, next bit after each falling sclk,
  // and captures mosi on each rising sclk.
  always @(negedge ce08) begin
    sbit = W8 - 1;
    slave_bit = reply[sbit];
  end
  always @(posedge sclk8) begin
    if (ce08 === 1'b0) begin
      slave_rx = {slave_rx[6:0], mosi8};
      rise_cnt++;
    end
  end
  always @(negedge sclk8) begin
    if (ce08 === 1'b0 && sbit > 0) begin
      sbit--;
      slave_bit = reply[sbit];
    end
  end

  // Behavioural model of the 8-bit instance: time since accept drives every output.
  logic       chk_en;
  logic       m_active, m_done, m_has;
  int         m_t;
  logic [7:0] m_word, m_exp_rx, m_rx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_has = 1'b0; m_t = 0; m_rx = 8'h00; m_word = 8'h00;
    end else if (chk_en) begin
      m_done = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == L8) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_rx     = m_exp_rx;
        end
      end else if (start8) begin
        m_active = 1'b1;
        m_t      = 0;
        m_word   = tx8;
        m_has    = 1'b1;
        m_exp_rx = loop8 ? tx8 : reply;
      end
    end
  end

  logic       e_ce0, e_sclk, e_busy, e_done, e_mosi;
  logic [7:0] e_rx;
  int         bi;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        e_ce0 = 1'b1; e_sclk = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rx = 8'h00; e_mosi = 1'b0;
      end else begin
        e_busy = m_active;
        e_ce0  = !m_active;
        e_done = m_done;
        e_rx   = m_rx;
        e_sclk = m_active && (m_t >= D8) && (m_t < D8 + 2 * D8 * W8) && (((m_t - D8) / D8) % 2 == 1);
        if (m_active) begin
          bi = (m_t < D8) ? 0 : (m_t - D8) / (2 * D8);
          if (bi > W8 - 1) bi = W8 - 1;
          e_mosi = m_word[W8-1-bi];
        end else begin
          e_mosi = m_has ? m_word[0] : 1'b0;
        end
      end
      check("cyc_ce0", ce08, e_ce0);
      check("cyc_sclk", sclk8, e_sclk);
      check("cyc_busy", busy8, e_busy);
      check("cyc_done", done8, e_done);
      check("cyc_mosi", mosi8, e_mosi);
      check("cyc_rx", rx8, e_rx);
    end
  end

  // One transfer on the 8-bit instance; poke>0 raises start with 0xFF on that cycle of the word.
  task automatic run8(input logic [7:0] tx, input int poke,
                      output int lat, output int ce_low, output int dn);
    int k;
    @(negedge clk);
    tx8 = tx; start8 = 1'b1; rise_cnt = 0; ce_low = 0; dn = 0; k = 0;
    do begin
      @(negedge clk);
      k++;
      start8 = (k == poke);
      if (k == poke) tx8 = 8'hFF;
      if (!ce08) ce_low++;
    end while (!done8 && k < 200);
    start8 = 1'b0;
    lat = k - 1;
    if (done8) dn = 1;
    repeat (45) begin
      @(negedge clk);
      if (done8) dn++;
    end
  endtask

  int lat, ce_low, dn, k, n, last_k, ce_hi;
  logic [15:0] w16 [3];
  logic [7:0]  rtx;

  initial begin
    rst_n = 1'b0; start8 = 1'b0; tx8 = 8'h00; loop8 = 1'b1; reply = 8'h00; chk_en = 1'b1;
    start16 = 1'b0; tx16 = 16'h0000; slave_rx = 8'h00; slave_bit = 1'b0; sbit = 0; rise_cnt = 0;
`ifdef SPI_MASTER_BURST_EN
    cont8 = 1'b0; cont16 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ce0", ce08, 1'b1);
    check("rst_sclk", sclk8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_rx", rx8, 8'h00);
    #2 rst_n = 1'b1;

    // Loopback 0xA5
    loop8 = 1'b1;
    run8(8'hA5, -1, lat, ce_low, dn);
    check("a5_latency", lat, 37);
    check("a5_rx", rx8, 8'hA5);
    check("a5_rises", rise_cnt, 8);
    check("a5_ce_low", ce_low, L8);
    check("a5_dones", dn, 1);

    // Slave reply 0x3C, send 0x00
    loop8 = 1'b0; reply = 8'h3C;
    run8(8'h00, -1, lat, ce_low, dn);
    check("slv_rx", rx8, 8'h3C);
    check("slv_cap", slave_rx, 8'h00);
    check("slv_rises", rise_cnt, 8);

    // Start while busy is ignored
    loop8 = 1'b1;
    run8(8'h6E, 10, lat, ce_low, dn);
    check("ign_rx", rx8, 8'h6E);
    check("ign_dones", dn, 1);

    // Randomized words, loopback or slave, optional start poke while busy
    for (int r = 0; r < 6; r++) begin
      loop8 = 1'($urandom_range(0, 1));
      reply = 8'($urandom);
      rtx   = 8'($urandom);
      run8(rtx, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1, lat, ce_low, dn);
      check("rnd_rx", rx8, loop8 ? rtx : reply);
      check("rnd_cap", slave_rx, rtx);
      check("rnd_lat", lat, L8);
      check("rnd_dones", dn, 1);
    end

    // Reset at cycle 20 of a transfer
    loop8 = 1'b1;
    @(negedge clk);
    tx8 = 8'h96; start8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ce0", ce08, 1'b1);
    check("mid_rst_sclk", sclk8, 1'b0);
    check("mid_rst_busy", busy8, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    dn = 0;
    repeat (50) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("mid_rst_nodone", dn, 0);
    check("mid_rst_rx", rx8, 8'h00);
    run8(8'h5A, -1, lat, ce_low, dn);
    check("post_rst_rx", rx8, 8'h5A);

    // 16-bit, CLK_DIV=1, start held high for three words
    w16[0] = 16'h1234; w16[1] = 16'hFFFF; w16[2] = 16'h0001;
    @(negedge clk);
    tx16 = w16[0]; start16 = 1'b1; n = 0; k = 0; last_k = 0;
    while (n < 3 && k < 400) begin
      @(negedge clk);
      k++;
      if (done16) begin
        check("w16_rx", rx16, w16[n]);
        check("w16_ce0_done", ce016, 1'b1);
        if (n == 0) check("w16_lat", k - 1, L16);
        else        check("w16_gap", k - last_k, L16 + 1);
        last_k = k;
        n++;
        if (n < 3) tx16 = w16[n];
        else       start16 = 1'b0;
      end else if (n > 0 && k == last_k + 1) begin
        check("w16_ce0_relow", ce016, 1'b0);
      end
    end
    start16 = 1'b0;
    check("w16_dones", n, 3);

`ifdef SPI_MASTER_BURST_EN
    // Burst: 0x11 with cont, then 0x22 without; ce0 stays low between
    @(negedge clk);
    chk_en = 1'b0;
    loop8 = 1'b1; tx8 = 8'h11; cont8 = 1'b1; start8 = 1'b1;
    n = 0; k = 0; last_k = 0; ce_hi = 0;
    while (n < 2 && k < 300) begin
      @(negedge clk);
      k++;
      if (done8) begin
        if (n == 0) begin
          check("bst_rx1", rx8, 8'h11);
          check("bst_ce0_mid", ce08, 1'b0);
          check("bst_lat1", k - 1, D8 + 2 * D8 * W8);
          tx8 = 8'h22; cont8 = 1'b0;
          last_k = k;
        end else begin
          check("bst_rx2", rx8, 8'h22);
          check("bst_ce0_end", ce08, 1'b1);
          check("bst_lat2", k - last_k - 1, 2 * D8 * W8 + D8 + 1);
          start8 = 1'b0;
        end
        n++;
      end else if (n == 1 && ce08) begin
        ce_hi++;
      end
    end
    start8 = 1'b0;
    check("bst_dones", n, 2);
    check("bst_ce0_stays_low", ce_hi, 0);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
